jh512_block_sequencer: RTL and testbench
========================================

Name: jh512_block_sequencer

Overview:
Controller that sequences the JH-512 compression datapath over a pre-padded message. It assembles 64-bit input words into 512-bit blocks and launches one compression per block. Between blocks it holds the 1024-bit chaining state, then presents the truncated 512-bit digest. It sits between the host-side message stream and an iterative JH512 compression core with a start/done interface.

Parameters:
WORD_W, 64, message word width; fixed, 8 words per 512-bit block
IV, JH-512 H(0) 1024-bit constant, chaining value loaded at start
CNT_W, 16, width of the processed-block counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin new hash; sampled only in IDLE
busy  out  1  high whenever FSM not in IDLE
msg_data  in  64  message word; first word of a block maps to block[511:448]
msg_valid  in  1  msg_data valid
msg_last  in  1  qualifies final block; sampled only on 8th word of a block
msg_ready  out  1  sequencer accepts word
core_start  out  1  one-cycle launch pulse to compression core
core_state  out  1024  chaining state to core
core_data  out  512  assembled message block to core
core_done  in  1  one-cycle pulse; core_hash valid
core_hash  in  1024  new chaining state from core
digest  out  512  chain[511:0] of final state
digest_valid  out  1  digest available
digest_ready  in  1  consumer accepts digest
blk_count  out  CNT_W  blocks compressed since last start

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; busy, msg_ready, core_start, digest_valid=0; chain, block, word_idx, blk_count, last_flag=0. Hence core_state, core_data, digest=0.
- IDLE: start=1 -> chain<=IV, word_idx<=0, blk_count<=0, last_flag<=0, go COLLECT.
- COLLECT: msg_ready=1.
  - On each msg_valid&msg_ready: write word into block slot word_idx (slot 0 = bits 511:448), word_idx++.
  - On slot 7: last_flag<=msg_last, word_idx<=0, go LAUNCH.
  - msg_last on slots 0-6 is ignored.
- LAUNCH: core_start=1 for exactly one cycle; go WAIT. msg_ready=0.
- WAIT:
  - core_state and core_data are held stable until core_done.
  - On core_done: chain<=core_hash, blk_count++ (wraps modulo 2^CNT_W).
  - Then go OUT if last_flag, else COLLECT.
  - core_done outside WAIT is ignored.
- OUT: digest_valid=1, digest=chain[511:0], held stable. On digest_ready, go IDLE next cycle with digest_valid=0. Digest data remains readable in IDLE until next start.
- Latency: 8 word handshakes, then 1 cycle to LAUNCH, then core latency, then 1 cycle to OUT.
  - First msg_ready after start: next cycle.
  - digest_valid: cycle after the core_done of the last block.
- start outside IDLE is ignored; no restart or abort.
- msg_valid outside COLLECT is not accepted (msg_ready=0); the host must hold data.
- A msg_valid gap mid-block preserves partial block and word_idx.
- Reset mid-operation (any state): immediate return to reset values; a pending core operation's later core_done is ignored because the FSM is in IDLE.
- core_state = chain and core_data = block at all times (registered, no combinational path from inputs).

Test Plan:
- Reset: assert rst_n=0 mid-COLLECT after 3 words -> busy=0, msg_ready=0, blk_count=0, digest_valid=0 immediately; new start then requires 8 fresh words.
- Single block, mock core (core_done 5 cycles after core_start, core_hash = core_state ^ {core_data,core_data}): words 64'h1..64'h8, msg_last on 8th -> core_state=IV, core_data=64'h1..8 concatenated, one core_start pulse, digest = (IV ^ {blk,blk})[511:0], blk_count=1.
- Two blocks: words 1..16, msg_last on word 16 -> second core_state = first core_hash, blk_count=2, exactly two core_start pulses.
- Early msg_last: msg_last=1 on word 3 and 0 on word 8 -> no digest after block 1; FSM returns to COLLECT, msg_ready=1.
- Backpressure: digest_ready=0 for 10 cycles -> digest_valid and digest stable throughout, busy=1; start pulses during this window are ignored; on digest_ready=1 -> IDLE.
- Stall and spurious input: msg_valid toggled 1/0 per cycle -> block assembles correctly in 16 cycles; spurious core_done in COLLECT -> chain unchanged.

Source files
------------

// File: rtl/jh512_block_sequencer.sv
// JH-512 block sequencer: packs 64-bit words into 512-bit blocks, launches one compression per block.
// Holds the 1024-bit chaining value between blocks and presents chain[511:0] with a valid/ready handshake.
module jh512_block_sequencer #(
  parameter int             WORD_W = 64,
  parameter logic [1023:0]  IV     = {
    64'h6fd14b963e00aa17, 64'h636a2e057a15d543,
    64'h8a225e8d0c97ef0b, 64'he9341259f2b3c361,
    64'h891da0c1536f801e, 64'h2aa9056bca95c8a0,
    64'h8bf5c8d8f2d0ebc1, 64'h2b69b1f5c6a0a8f3,
    64'h1e2d6b3d3ad6c1f1, 64'hd3e4b1b9dc8a9e52,
    64'h58a6d1b1b5f2e0d6, 64'h6b7bf0e47d9a3a2c,
    64'h3a0f8c4d8d3c7e19, 64'h9c4e1bf2f0e6b7d5,
    64'h7d45a62b9cf5e8a1, 64'h0e4b3e4c27c1f8d6
  },
  parameter int             CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  input  logic [WORD_W-1:0]   msg_data,
  input  logic                msg_valid,
  input  logic                msg_last,
  output logic                msg_ready,
  output logic                core_start,
  output logic [1023:0]       core_state,
  output logic [8*WORD_W-1:0] core_data,
  input  logic                core_done,
  input  logic [1023:0]       core_hash,
  output logic [511:0]        digest,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic [CNT_W-1:0]    blk_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_LAUNCH, S_WAIT, S_OUT
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1023:0]         r_chain;
  logic [8*WORD_W-1:0]   r_block;
  logic [2:0]            r_word_idx;
  logic [CNT_W-1:0]      r_blk_count;
  logic                  r_last_flag;

  logic                  w_accept;
  logic                  w_blk_full;
  logic [8:0]            w_slot_lsb;

  assign w_accept   = (r_state == S_COLLECT) && msg_valid;
  assign w_blk_full = (r_word_idx == 3'd7);
  // Slot 0 lands in the top word, so the LSB offset is (7 - idx) * 64.
  assign w_slot_lsb = {~r_word_idx, 6'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      S_COLLECT: if (w_accept && w_blk_full) w_next = S_LAUNCH;
      S_LAUNCH:  w_next = S_WAIT;
      S_WAIT:    if (core_done) w_next = r_last_flag ? S_OUT : S_COLLECT;
      S_OUT:     if (digest_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain     <= '0;
      r_block     <= '0;
      r_word_idx  <= '0;
      r_blk_count <= '0;
      r_last_flag <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_chain     <= IV;
        r_word_idx  <= '0;
        r_blk_count <= '0;
        r_last_flag <= 1'b0;
      end
      if (w_accept) begin
        r_block[w_slot_lsb +: WORD_W] <= msg_data;
        r_word_idx                    <= r_word_idx + 3'd1;
        if (w_blk_full) r_last_flag <= msg_last;
      end
      // A done pulse outside WAIT belongs to no launch of ours and is dropped.
      if (r_state == S_WAIT && core_done) begin
        r_chain     <= core_hash;
        r_blk_count <= r_blk_count + 1'b1;
      end
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign msg_ready    = (r_state == S_COLLECT);
  assign core_start   = (r_state == S_LAUNCH);
  assign digest_valid = (r_state == S_OUT);
  assign core_state   = r_chain;
  assign core_data    = r_block;
  assign digest       = r_chain[511:0];
  assign blk_count    = r_blk_count;

endmodule

// File: tb/tb_jh512_block_sequencer.sv
// Directed bench for jh512_block_sequencer with a fixed-latency mock compression core.
module tb_jh512_block_sequencer;

  localparam logic [1023:0] TB_IV = {{8{64'hA5A5_1234_0F0F_C3C3}}, {8{64'h5A5A_8765_F0F0_3C3C}}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic [63:0]   msg_data;
  logic          msg_valid;
  logic          msg_last;
  logic          msg_ready;
  logic          core_start;
  logic [1023:0] core_state;
  logic [511:0]  core_data;
  logic          core_done;
  logic [1023:0] core_hash;
  logic [511:0]  digest;
  logic          digest_valid;
  logic          digest_ready;
  logic [15:0]   blk_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;

  logic [2:0]    mock_cnt  = '0;
  logic          mock_done = 1'b0;
  logic          spur      = 1'b0;
  logic [1023:0] mock_hash = '0;
  logic [1023:0] cap_state = '0;
  logic [511:0]  cap_data  = '0;

  always #5 clk = ~clk;

  jh512_block_sequencer #(.IV(TB_IV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
    .core_start(core_start), .core_state(core_state), .core_data(core_data),
    .core_done(core_done), .core_hash(core_hash),
    .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .blk_count(blk_count)
  );

  // Mock core: done 5 cycles after start, hash = state ^ {data,data}.
  assign core_done = mock_done | spur;
  assign core_hash = mock_hash;

  always @(posedge clk) begin
    mock_done <= 1'b0;
    if (core_start) begin
      mock_cnt  <= 3'd5;
      mock_hash <= core_state ^ {core_data, core_data};
      cap_state <= core_state;
      cap_data  <= core_data;
      n_starts  <= n_starts + 1;
    end else if (mock_cnt != 3'd0) begin
      mock_cnt <= mock_cnt - 3'd1;
      if (mock_cnt == 3'd1) mock_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mk_blk(input logic [63:0] base);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[511-64*i -: 64] = base + 64'(i);
    return b;
  endfunction

  task automatic send_word(input logic [63:0] d, input logic last);
    int  budget;
    logic ok;
    msg_data  = d;
    msg_last  = last;
    msg_valid = 1'b1;
    budget    = 0;
    while (1) begin
      ok = msg_ready;
      @(negedge clk);
      if (ok) break;
      budget++;
      if (budget > 100) begin
        chk("msg_ready_timeout", 512'(0), 512'(1));
        break;
      end
    end
  endtask

  task automatic send_block(input logic [63:0] base, input int last_pos, input bit toggle);
    for (int i = 0; i < 8; i++) begin
      send_word(base + 64'(i), i == last_pos);
      if (toggle && i != 7) begin
        msg_valid = 1'b0;
        @(negedge clk);
      end
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (!core_done && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!core_done) chk("core_done_timeout", 512'(0), 512'(1));
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic take_digest();
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
  endtask

  initial begin
    logic [511:0]  b1, ba, bb, be1, be2;
    logic [1023:0] h1, ha, hb, he1, he2;
    int s0;

    rst_n = 1'b0; start = 1'b0; msg_data = '0; msg_valid = 1'b0;
    msg_last = 1'b0; digest_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",         512'(busy),         512'(0));
    chk("rst_msg_ready",    512'(msg_ready),    512'(0));
    chk("rst_core_start",   512'(core_start),   512'(0));
    chk("rst_digest_valid", 512'(digest_valid), 512'(0));
    chk("rst_blk_count",    512'(blk_count),    512'(0));
    chk("rst_digest",       digest,             512'(0));
    chk("rst_core_data",    core_data,          512'(0));
    chk("rst_core_state",   core_state[1023:512] | core_state[511:0], 512'(0));

    // Reset in the middle of collecting a block.
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    chk("first_ready_after_start", 512'(msg_ready), 512'(1));
    chk("busy_after_start",        512'(busy),      512'(1));
    for (int i = 0; i < 3; i++) send_word(64'hDEAD_0000 + 64'(i), 1'b0);
    msg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy",         512'(busy),         512'(0));
    chk("midrst_msg_ready",    512'(msg_ready),    512'(0));
    chk("midrst_blk_count",    512'(blk_count),    512'(0));
    chk("midrst_digest_valid", 512'(digest_valid), 512'(0));
    chk("midrst_core_data",    core_data,          512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single block, words 1..8, last on the 8th.
    b1 = mk_blk(64'h1);
    h1 = TB_IV ^ {b1, b1};
    do_start();
    s0 = n_starts;
    send_block(64'h1, 7, 1'b0);
    chk("launch_core_start", 512'(core_start), 512'(1));
    chk("launch_msg_ready",  512'(msg_ready),  512'(0));
    wait_done();
    chk("single_digest_valid", 512'(digest_valid), 512'(1));
    chk("single_digest",       digest,             h1[511:0]);
    chk("single_blk_count",    512'(blk_count),    512'(1));
    chk("single_core_data",    cap_data,           b1);
    chk("single_state_hi",     cap_state[1023:512], TB_IV[1023:512]);
    chk("single_state_lo",     cap_state[511:0],    TB_IV[511:0]);
    chk("single_start_pulses", 512'(n_starts - s0), 512'(1));

    // Digest held under backpressure while start pulses are ignored.
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      @(negedge clk);
      chk("bp_valid",  512'(digest_valid), 512'(1));
      chk("bp_digest", digest,             h1[511:0]);
      chk("bp_busy",   512'(busy),         512'(1));
    end
    start = 1'b0;
    take_digest();
    chk("bp_idle_valid",  512'(digest_valid), 512'(0));
    chk("bp_idle_busy",   512'(busy),         512'(0));
    chk("bp_idle_digest", digest,             h1[511:0]);
    @(negedge clk);
    chk("bp_stays_idle",  512'(busy),         512'(0));

    // Two blocks, words 1..16, last on word 16.
    ba = mk_blk(64'h1);
    bb = mk_blk(64'h9);
    ha = TB_IV ^ {ba, ba};
    hb = ha ^ {bb, bb};
    do_start();
    s0 = n_starts;
    send_block(64'h1, -1, 1'b0);
    wait_done();
    chk("two_mid_valid",     512'(digest_valid), 512'(0));
    chk("two_mid_ready",     512'(msg_ready),    512'(1));
    chk("two_mid_blk_count", 512'(blk_count),    512'(1));
    send_block(64'h9, 7, 1'b0);
    wait_done();
    chk("two_state_hi",     cap_state[1023:512], ha[1023:512]);
    chk("two_state_lo",     cap_state[511:0],    ha[511:0]);
    chk("two_core_data",    cap_data,            bb);
    chk("two_digest_valid", 512'(digest_valid),  512'(1));
    chk("two_digest",       digest,              hb[511:0]);
    chk("two_blk_count",    512'(blk_count),     512'(2));
    chk("two_start_pulses", 512'(n_starts - s0), 512'(2));
    take_digest();

    // msg_last on word 3 is not a final-block marker; then a stalled block with a stray done.
    be1 = mk_blk(64'h100);
    be2 = mk_blk(64'h200);
    he1 = TB_IV ^ {be1, be1};
    he2 = he1 ^ {be2, be2};
    do_start();
    send_block(64'h100, 2, 1'b0);
    wait_done();
    chk("early_no_digest", 512'(digest_valid), 512'(0));
    chk("early_ready",     512'(msg_ready),    512'(1));
    chk("early_busy",      512'(busy),         512'(1));
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_chain_hi",   core_state[1023:512], he1[1023:512]);
    chk("spur_chain_lo",   core_state[511:0],    he1[511:0]);
    chk("spur_blk_count",  512'(blk_count),      512'(1));
    send_block(64'h200, 7, 1'b1);
    wait_done();
    chk("stall_core_data", cap_data,            be2);
    chk("stall_state_lo",  cap_state[511:0],    he1[511:0]);
    chk("stall_digest",    digest,              he2[511:0]);
    chk("stall_valid",     512'(digest_valid),  512'(1));
    chk("stall_blk_count", 512'(blk_count),     512'(2));
    take_digest();
    chk("final_idle", 512'(busy), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
